// File: rtl/otter_pkg.sv
// Shared fetch-stage types: the fetch FSM state encoding and the queued instruction entry.
package otter_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: power-of-two deep queue of fetch entries with push/pop/flush and an occupancy count.
module sync_fifo
  import otter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   head_reg;
  logic [AW-1:0]   tail_reg;
  logic [AW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count_reg != FULL_CNT) && !flush && !RST;
  assign do_pop  = pop && (count_reg != '0) && !flush && !RST;

  // Storage has no reset; only the pointers define what is live.
  always_ff @(posedge CLK) begin
    if (do_push) mem[tail_reg] <= din;
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[head_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-based issue to IMEM, queue to decode, redirect flush.
// Define FETCH_QUEUE_STATS_EN to add FLUSH_CNT / EMPTY_CNT statistics outputs.
module fetch_queue
  import otter_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_RD,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        DE_VALID,
  input  logic        DE_READY,
  output logic [31:0] DE_IR,
  output logic [31:0] DE_PC,
  output logic [31:0] DE_NEXT_PC
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] FLUSH_CNT,
  output logic [31:0] EMPTY_CNT
`endif
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  fetch_state_t  state_reg;
  logic [31:0]   fpc_reg;
  logic [31:0]   inf_pc_reg;
  logic          inf_reg;
  logic [AW:0]   occ;
  fetch_entry_t  head;
  fetch_entry_t  tail_entry;
  logic          flush;
  logic          push;
  logic          pop;
  logic          credit;
  logic          issue;

  // Redirect and reset both discard the queue and the returning response.
  assign flush    = RST | REDIRECT;
  assign DE_VALID = (occ != '0) && !flush;
  assign pop      = DE_VALID && DE_READY;
  assign push     = inf_reg && !flush;
  assign credit   = ((occ + {{AW{1'b0}}, inf_reg}) < DEPTH_CNT) || pop;
  assign issue    = (state_reg == FETCH) && credit && !flush;

  assign IMEM_RD    = issue;
  assign IMEM_ADDR  = fpc_reg;
  assign tail_entry = '{ir: IMEM_DATA, pc: inf_pc_reg};

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (tail_entry),
    .dout  (head),
    .count (occ)
  );

  assign DE_IR      = head.ir;
  assign DE_PC      = head.pc;
  assign DE_NEXT_PC = pc_plus4(head.pc);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= FETCH;
      fpc_reg    <= RESET_PC;
      inf_pc_reg <= '0;
      inf_reg    <= 1'b0;
    end else if (REDIRECT) begin
      state_reg <= REDIR;
      fpc_reg   <= word_align(REDIRECT_PC);
      inf_reg   <= 1'b0;
    end else begin
      inf_reg <= issue;
      if (issue) begin
        inf_pc_reg <= fpc_reg;
        fpc_reg    <= pc_plus4(fpc_reg);
      end
      case (state_reg)
        FETCH:   if (!credit) state_reg <= HOLD;
        HOLD:    if (credit)  state_reg <= FETCH;
        REDIR:   state_reg <= FETCH;
        default: state_reg <= FETCH;
      endcase
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      FLUSH_CNT <= '0;
      EMPTY_CNT <= '0;
    end else begin
      if (REDIRECT && (FLUSH_CNT != '1)) FLUSH_CNT <= FLUSH_CNT + 1'b1;
      if (!DE_VALID && (state_reg != REDIR) && (EMPTY_CNT != '1)) EMPTY_CNT <= EMPTY_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed stimulus pushes expected decode PCs, a monitor pops and compares.
module tb_fetch_queue;

  logic        CLK;
  logic        RST;
  logic        IMEM_RD;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        DE_VALID;
  logic        DE_READY;
  logic [31:0] DE_IR;
  logic [31:0] DE_PC;
  logic [31:0] DE_NEXT_PC;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] FLUSH_CNT;
  logic [31:0] EMPTY_CNT;
`endif

  int          vectors;
  int          miscompares;
  int          issue_cnt;
  logic [31:0] exp_q [$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IMEM_RD     (IMEM_RD),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_DATA   (IMEM_DATA),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .DE_VALID    (DE_VALID),
    .DE_READY    (DE_READY),
    .DE_IR       (DE_IR),
    .DE_PC       (DE_PC),
    .DE_NEXT_PC  (DE_NEXT_PC)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .FLUSH_CNT   (FLUSH_CNT),
    .EMPTY_CNT   (EMPTY_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ir_of(input logic [31:0] addr);
    return addr ^ 32'hDEAD_BEEF;
  endfunction

  // Instruction memory: word returned the cycle after the address is presented.
  always @(posedge CLK) IMEM_DATA <= ir_of(IMEM_ADDR);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: count issues and check every accepted head against the scoreboard.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (!RST && IMEM_RD) issue_cnt++;
    if (DE_VALID && DE_READY) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_delivery: got pc %h expected none", DE_PC);
      end else begin
        e = exp_q.pop_front();
        chk("de_pc", DE_PC, e);
        chk("de_next_pc", DE_NEXT_PC, e + 32'd4);
        chk("de_ir", DE_IR, ir_of(e));
      end
    end
  end

  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
    @(posedge CLK);
    #1;
    RST         = rst;
    DE_READY    = rdy;
    REDIRECT    = redir;
    REDIRECT_PC = rpc;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    issue_cnt   = 0;
    RST         = 1'b1;
    DE_READY    = 1'b1;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;

    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_imem_rd", 32'(IMEM_RD), 32'd0);
    chk("rst_de_valid", 32'(DE_VALID), 32'd0);
    chk("rst_imem_addr", IMEM_ADDR, 32'h0);

    // Reset release with decode always ready: fetch 0,4,8..., first delivery two cycles later.
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("stream_imem_rd", 32'(IMEM_RD), 32'd1);
      chk("stream_imem_addr", IMEM_ADDR, 32'(4 * k));
      if (k < 2) chk("stream_latency_valid", 32'(DE_VALID), 32'd0);
      if (k == 2) chk("stream_first_valid", 32'(DE_VALID), 32'd1);
    end

    // Reset mid-stream discards queued and in-flight words.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("midrst_de_valid", 32'(DE_VALID), 32'd0);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    issue_cnt = 0;

    // Decode stalled: exactly DEPTH issues, then HOLD with head PC 0.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (k == 0) chk("release_addr", IMEM_ADDR, 32'h0);
      if (k == 4 || k == 9) chk("hold_imem_rd", 32'(IMEM_RD), 32'd0);
      if (k == 5) chk("hold_head_pc", DE_PC, 32'h0);
    end
    chk("stall_issue_count", 32'(issue_cnt), 32'd4);
    chk("stall_de_valid", 32'(DE_VALID), 32'd1);
    chk("stall_head_pc", DE_PC, 32'h0);
    chk("stall_head_ir", DE_IR, ir_of(32'h0));
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(4 * k));
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect to 0x100 with three queued entries and one read in flight.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    chk("redir_de_valid", 32'(DE_VALID), 32'd0);
    chk("redir_imem_rd", 32'(IMEM_RD), 32'd0);
    chk("resume_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("redir_cycle_rd", 32'(IMEM_RD), 32'd0);
    chk("redir_cycle_addr", IMEM_ADDR, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("redir_fetch_rd", 32'(IMEM_RD), 32'd1);
    chk("redir_fetch_addr", IMEM_ADDR, 32'h100);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect target is forced to a word boundary.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0203);
    chk("align_de_valid", 32'(DE_VALID), 32'd0);
    chk("redir100_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("align_addr", IMEM_ADDR, 32'h200);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("align_fetch_rd", 32'(IMEM_RD), 32'd1);
    chk("align_fetch_addr", IMEM_ADDR, 32'h200);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect to the last word: fetch PC and DE_NEXT_PC wrap to 0.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("align_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_fetch_addr_top", IMEM_ADDR, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_fetch_rd", 32'(IMEM_RD), 32'd1);
    chk("wrap_fetch_addr_zero", IMEM_ADDR, 32'h0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect and pop together with one entry queued: head (PC 4) must not be delivered.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
    chk("pop_redir_de_valid", 32'(DE_VALID), 32'd0);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pop_redir_drained", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_QUEUE_STATS_EN
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
    chk("flush_cnt_three", FLUSH_CNT, 32'd3);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("flush_cnt_reset", FLUSH_CNT, 32'd0);
    chk("empty_cnt_reset", EMPTY_CNT, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
